// File: rtl/mbisr_remap.sv
// mbisr_remap: built-in self-repair stage that records MBIST failing addresses
// into spare word registers and remaps functional accesses to them after the run.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   bist_start, bist_done     MBIST run start pulse / completion level
//   fail_valid, fail_addr     failing-address stream from the MBIST controller
//   func_we/addr/wdata/rdata  functional memory port (rdata one-cycle latency)
//   mem_we/addr/wdata/rdata   memory macro port (synchronous read)
//   repair_ok, repair_fail    run done and fully repaired / run done with too many fails
//   spares_used               number of allocated spare entries
module mbisr_remap #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SPARES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bist_start,
    input  logic              bist_done,
    input  logic              fail_valid,
    input  logic [ADDR_W-1:0] fail_addr,
    input  logic              func_we,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [DATA_W-1:0] func_wdata,
    output logic [DATA_W-1:0] func_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              repair_ok,
    output logic              repair_fail,
    output logic [4:0]        spares_used
);
    typedef enum logic [1:0] {IDLE, COLLECT, REPAIRED, UNREPAIRABLE} state_t;
    state_t              state_q, state_d;
    logic [NUM_SPARES-1:0] valid_q;
    logic [ADDR_W-1:0]   addr_q [NUM_SPARES];
    logic [DATA_W-1:0]   data_q [NUM_SPARES];
    logic [4:0]          count_q, count_d;
    logic                ovf_q, ovf_d, hit_q;
    logic [DATA_W-1:0]   spare_q, hit_data;
    logic [NUM_SPARES-1:0] hit_oh;
    logic                fail_dup, hit, capture, alloc;

    // Lowest matching entry wins; the table never holds duplicates anyway.
    always_comb begin
        fail_dup = 1'b0;
        hit      = 1'b0;
        hit_oh   = '0;
        hit_data = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            fail_dup = fail_dup | (valid_q[i] && addr_q[i] == fail_addr);
            if (!hit && state_q == REPAIRED && valid_q[i] && addr_q[i] == func_addr) begin
                hit       = 1'b1;
                hit_oh[i] = 1'b1;
                hit_data  = data_q[i];
            end
        end
    end

    assign capture = state_q == COLLECT && fail_valid && !fail_dup;
    assign alloc   = capture && count_q < 5'(NUM_SPARES);
    assign ovf_d   = ovf_q | (capture && !alloc);
    assign count_d = count_q + {4'b0, alloc};

    // A fail arriving with bist_done is folded into ovf_d before the decision.
    always_comb begin
        state_d = state_q;
        state_d = bist_start ? COLLECT :
                  (state_q == COLLECT && bist_done) ? (ovf_d ? UNREPAIRABLE : REPAIRED) : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            hit_q   <= 1'b0;
            spare_q <= '0;
            for (int i = 0; i < NUM_SPARES; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            hit_q   <= hit;
            spare_q <= hit_data;
            if (bist_start) begin
                valid_q <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
                for (int i = 0; i < NUM_SPARES; i++) begin
                    addr_q[i] <= '0;
                    data_q[i] <= '0;
                end
            end else begin
                count_q <= count_d;
                ovf_q   <= ovf_d;
                for (int i = 0; i < NUM_SPARES; i++) begin
                    if (alloc && count_q == 5'(i)) begin
                        valid_q[i] <= 1'b1;
                        addr_q[i]  <= fail_addr;
                        data_q[i]  <= '0;
                    end else if (hit_oh[i] && func_we) begin
                        data_q[i] <= func_wdata;
                    end
                end
            end
        end
    end

    assign mem_addr    = func_addr;
    assign mem_wdata   = func_wdata;
    assign mem_we      = func_we && !hit;
    assign func_rdata  = hit_q ? spare_q : mem_rdata;
    assign repair_ok   = state_q == REPAIRED;
    assign repair_fail = state_q == UNREPAIRABLE;
    assign spares_used = count_q;
endmodule

// File: tb/tb_mbisr_remap.sv
// tb_mbisr_remap: table, directed and random checks of mbisr_remap against a queue-based repair model.
module tb_mbisr_remap;
    localparam int NS = 4;
    logic       clk = 0, rst = 0;
    logic       bist_start = 0, bist_done = 0, fail_valid = 0, func_we = 0;
    logic [7:0] fail_addr = 0, func_addr = 0, func_wdata = 0, mem_rdata = 0;
    logic [7:0] func_rdata, mem_addr, mem_wdata;
    logic       mem_we, repair_ok, repair_fail;
    logic [4:0] spares_used;

    mbisr_remap #(.ADDR_W(8), .DATA_W(8), .NUM_SPARES(NS)) dut (
        .clk(clk), .rst(rst), .bist_start(bist_start), .bist_done(bist_done),
        .fail_valid(fail_valid), .fail_addr(fail_addr), .func_we(func_we),
        .func_addr(func_addr), .func_wdata(func_wdata), .func_rdata(func_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .repair_ok(repair_ok), .repair_fail(repair_fail),
        .spares_used(spares_used));

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int         r_state;
    logic [7:0] r_fails[$];
    bit         r_ovf, rd_vld;
    logic [7:0] r_spare[logic [7:0]];
    logic [7:0] rd_exp;
    int         n_cmp = 0, n_err = 0;
    logic       s_ok, s_fail, s_mwe;
    logic [4:0] s_used;
    logic [7:0] s_rd;

    typedef struct {
        bit bs, bd, fv; logic [7:0] fa; bit we; logic [7:0] a, wd;
        bit e_ok, e_fail; int e_used; bit e_mwe; bit crd; logic [7:0] e_rd;
    } vec_t;
    vec_t tv[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_fails(input logic [7:0] x);
        foreach (r_fails[k]) if (r_fails[k] == x) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input bit bs, bd, fv, input logic [7:0] fa, input bit we,
                        input logic [7:0] a, wd);
        bit hit;
        bist_start = bs; bist_done = bd; fail_valid = fv; fail_addr = fa;
        func_we = we; func_addr = a; func_wdata = wd;
        #4;
        s_ok = repair_ok; s_fail = repair_fail; s_mwe = mem_we; s_used = spares_used; s_rd = func_rdata;
        hit = r_state == 2 && in_fails(a);
        chk("repair_ok", repair_ok, r_state == 2);
        chk("repair_fail", repair_fail, r_state == 3);
        chk("spares_used", spares_used, r_fails.size());
        chk("mem_we", mem_we, we && !hit);
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, wd);
        if (rd_vld) chk("func_rdata", func_rdata, rd_exp);
        rd_vld = 1;
        rd_exp = hit ? r_spare[a] : mem[a];
        if (bs) begin
            r_state = 1; r_fails.delete(); r_ovf = 0; r_spare.delete();
        end else begin
            if (r_state == 1 && fv && !in_fails(fa)) begin
                if (r_fails.size() < NS) begin
                    r_fails.push_back(fa);
                    r_spare[fa] = 8'h00;
                end else r_ovf = 1;
            end
            if (r_state == 1 && bd) r_state = r_ovf ? 3 : 2;
            else if (hit && we) r_spare[a] = wd;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_used", spares_used, 0);
        chk("rst_ok", repair_ok, 0);
        chk("rst_fail", repair_fail, 0);
        chk("rst_rdata", func_rdata, mem_rdata);
        r_state = 0; r_fails.delete(); r_ovf = 0; r_spare.delete(); rd_vld = 0;
        #2 rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit bd, input int n);
        repeat (n) step(0, bd, 0, 8'h00, 0, 8'h00, 8'h00);
    endtask

    task automatic fail(input logic [7:0] fa);
        step(0, 0, 1, fa, 0, 8'h00, 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
        tv[0]  = '{1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00};
        tv[1]  = '{0, 0, 1, 8'h03, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00};
        tv[2]  = '{0, 0, 1, 8'h80, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00};
        tv[3]  = '{0, 0, 1, 8'h03, 0, 8'h00, 8'h00, 0, 0, 2, 0, 0, 8'h00};
        tv[4]  = '{0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 2, 0, 0, 8'h00};
        tv[5]  = '{0, 1, 0, 8'h00, 1, 8'h80, 8'h5A, 1, 0, 2, 0, 0, 8'h00};
        tv[6]  = '{0, 1, 0, 8'h00, 0, 8'h80, 8'h00, 1, 0, 2, 0, 1, 8'h00};
        tv[7]  = '{0, 1, 0, 8'h00, 0, 8'h81, 8'h00, 1, 0, 2, 0, 1, 8'h5A};
        tv[8]  = '{0, 1, 0, 8'h00, 1, 8'h81, 8'h33, 1, 0, 2, 1, 1, 8'h42};
        tv[9]  = '{0, 1, 0, 8'h00, 0, 8'h81, 8'h00, 1, 0, 2, 0, 1, 8'h42};
        tv[10] = '{0, 1, 0, 8'h00, 0, 8'h81, 8'h00, 1, 0, 2, 0, 1, 8'h33};

        @(posedge clk); #1;
        do_reset();

        foreach (tv[i]) begin
            step(tv[i].bs, tv[i].bd, tv[i].fv, tv[i].fa, tv[i].we, tv[i].a, tv[i].wd);
            chk($sformatf("vec%0d_ok", i), s_ok, tv[i].e_ok);
            chk($sformatf("vec%0d_fail", i), s_fail, tv[i].e_fail);
            chk($sformatf("vec%0d_used", i), s_used, tv[i].e_used);
            chk($sformatf("vec%0d_mem_we", i), s_mwe, tv[i].e_mwe);
            if (tv[i].crd) chk($sformatf("vec%0d_rdata", i), s_rd, tv[i].e_rd);
        end

        // no fails over a long run
        step(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        idle(0, 512);
        idle(1, 2);
        chk("nofail_ok", s_ok, 1);
        chk("nofail_used", s_used, 0);
        step(0, 1, 0, 8'h00, 1, 8'h10, 8'hA5);
        chk("nofail_mem_we", s_mwe, 1);
        step(0, 1, 0, 8'h00, 0, 8'h10, 8'h00);
        step(0, 1, 0, 8'h00, 0, 8'h10, 8'h00);
        chk("nofail_rdata", s_rd, 8'hA5);

        // more distinct fails than spares
        step(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        for (int k = 1; k <= 5; k++) fail(8'(k));
        idle(1, 2);
        chk("ovf_used", s_used, 4);
        chk("ovf_fail", s_fail, 1);
        chk("ovf_ok", s_ok, 0);
        step(0, 1, 0, 8'h00, 1, 8'h01, 8'h99);
        chk("ovf_passthru", s_mwe, 1);

        // fail together with done, count 3 then count 4
        step(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) fail(8'h11 + 8'(k));
        step(0, 1, 1, 8'h07, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        chk("same3_used", s_used, 4);
        chk("same3_ok", s_ok, 1);
        step(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) fail(8'h11 + 8'(k));
        step(0, 1, 1, 8'h07, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        chk("same4_fail", s_fail, 1);
        chk("same4_used", s_used, 4);

        // rerun replaces the old table
        step(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        fail(8'h03);
        idle(1, 2);
        chk("run1_ok", s_ok, 1);
        step(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        idle(0, 1);
        chk("rerun_used", s_used, 0);
        chk("rerun_ok", s_ok, 0);
        fail(8'h22);
        idle(1, 2);
        step(0, 1, 0, 8'h00, 1, 8'h03, 8'h77);
        chk("old_not_remapped", s_mwe, 1);
        step(0, 1, 0, 8'h00, 1, 8'h22, 8'h66);
        chk("new_remapped", s_mwe, 0);
        step(0, 1, 0, 8'h00, 0, 8'h22, 8'h00);
        step(0, 1, 0, 8'h00, 0, 8'h22, 8'h00);
        chk("new_rdata", s_rd, 8'h66);

        // async reset mid-collect
        step(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        fail(8'h40);
        fail(8'h41);
        idle(0, 1);
        chk("mid_used", s_used, 2);
        do_reset();
        idle(1, 3);
        chk("post_rst_ok", s_ok, 0);
        chk("post_rst_fail", s_fail, 0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] fa, a;
            fa = 8'h30 + 8'($urandom % 10);
            a  = ($urandom % 2) ? 8'h30 + 8'($urandom % 10) : 8'($urandom);
            if ($urandom % 600 == 0) do_reset();
            else step($urandom % 150 == 0, $urandom % 12 == 0, $urandom % 5 == 0, fa,
                      $urandom % 2 == 0, a, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
